// File: rtl/inst_line_cache.sv
// Direct-mapped instruction line cache: combinational lookup of whole lines, with a
// word-serial refill from instruction memory over a single-outstanding req/ack bus.
module inst_line_cache #(
    parameter int WORD_SIZE  = 32,
    parameter int LINE_WORDS = 32,
    parameter int NUM_LINES  = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           in,
    output logic [WORD_SIZE*LINE_WORDS-1:0] out,
    output logic                            hit,
    input  logic                            inv,
    output logic                            mem_req,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic                            mem_ack,
    input  logic [WORD_SIZE-1:0]            mem_rdata
);
    localparam int LINE_BITS = WORD_SIZE * LINE_WORDS;
    localparam int OFF_W     = $clog2(LINE_BITS / 8);
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int TAG_W     = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int K_W       = $clog2(LINE_WORDS);
    localparam int BYTE_W    = $clog2(WORD_SIZE / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;
    logic [K_W-1:0]        k_reg, k_next;

    logic [WORD_SIZE-1:0]  fill_reg [LINE_WORDS];
    logic [LINE_BITS-1:0]  fill_line;
    logic [NUM_LINES-1:0]  valid_reg;
    logic [TAG_W-1:0]      tag_reg  [NUM_LINES];
    logic [LINE_BITS-1:0]  data_reg [NUM_LINES];

    logic [IDX_W-1:0]      index, fill_index;
    logic [TAG_W-1:0]      tag, fill_tag;
    logic                  lookup_hit;
    logic                  fill_we;
    logic                  commit;
    logic                  unused_offset;

    assign index         = in[OFF_W +: IDX_W];
    assign tag           = in[ADDR_WIDTH-1 -: TAG_W];
    assign fill_index    = base_reg[OFF_W +: IDX_W];
    assign fill_tag      = base_reg[ADDR_WIDTH-1 -: TAG_W];
    assign unused_offset = ^in[OFF_W-1:0];

    // A line being committed this cycle is not yet visible, even if its old copy matches.
    assign lookup_hit = valid_reg[index] && (tag_reg[index] == tag);
    assign hit        = lookup_hit && !(state_reg == WRITE && fill_index == index);
    assign out        = data_reg[index];

    assign mem_req  = (state_reg == FILL);
    assign mem_addr = base_reg + (ADDR_WIDTH'(k_reg) << BYTE_W);

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        k_next     = k_reg;
        fill_we    = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!inv && !lookup_hit) begin
                    base_next  = {in[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    k_next     = '0;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (inv) begin
                    k_next     = '0;
                    state_next = IDLE;
                end else if (mem_ack) begin
                    fill_we = 1'b1;
                    k_next  = k_reg + 1'b1;
                    if (k_reg == K_W'(LINE_WORDS - 1)) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                commit     = !inv;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            k_reg     <= k_next;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            fill_reg[k_reg] <= mem_rdata;
        end
    end

    // Word k lands in the most significant slot first, matching the fetch stage's walk order.
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_fill_line
        assign fill_line[(LINE_WORDS-1-gi)*WORD_SIZE +: WORD_SIZE] = fill_reg[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_reg[i] <= '0;
            end
        end else if (inv) begin
            valid_reg <= '0;
        end else if (commit) begin
            valid_reg[fill_index] <= 1'b1;
            tag_reg[fill_index]   <= fill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            data_reg[fill_index] <= fill_line;
        end
    end

endmodule

// File: tb/tb_inst_line_cache.sv
// Self-checking bench for inst_line_cache: directed scenarios plus randomized lookups,
// checked against a line-address model of the cache and a wait-state memory model.
module tb_inst_line_cache;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   pc = '0;
    logic [1023:0] line;
    logic          hit;
    logic          inv = 1'b0;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;

    int errors = 0;
    int checks = 0;
    int wait_cycles = 0;
    int stable_viol = 0;
    logic [31:0] ack_log[$];

    bit          model_valid[8];
    logic [31:0] model_base[8];

    inst_line_cache #(
        .WORD_SIZE(32), .LINE_WORDS(32), .NUM_LINES(8), .ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .in(pc), .out(line), .hit(hit), .inv(inv),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    function automatic logic [1023:0] line_of(input logic [31:0] base);
        logic [1023:0] l;
        for (int w = 0; w < 32; w++) l[1023-32*w -: 32] = mem_word(base + 32'(4 * w));
        return l;
    endfunction

    function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
        for (int w = 0; w < 32; w++) if (a[1023-32*w -: 32] !== b[1023-32*w -: 32]) return w;
        return 0;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return model_valid[a[9:7]] && (model_base[a[9:7]] == (a & ~32'h7F));
    endfunction

    function automatic void model_fill(input logic [31:0] base);
        model_valid[base[9:7]] = 1'b1;
        model_base[base[9:7]]  = base;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
    endfunction

    // Memory: acks after wait_cycles idle cycles, logs acked addresses, throws stray acks when idle.
    initial begin : memory_model
        int    wcnt = 0;
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req === 1'b1 && prev_req && !prev_ack && mem_addr !== prev_addr) stable_viol++;
            prev_req  = (mem_req === 1'b1);
            prev_addr = mem_addr;
            if (mem_req === 1'b1) begin
                if (wcnt >= wait_cycles) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    ack_log.push_back(mem_addr);
                    wcnt      = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    wcnt++;
                end
                prev_ack = mem_ack;
            end else begin
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
                wcnt      = 0;
                prev_ack  = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_hit(input int max, output int cycles);
        cycles = 0;
        while (hit !== 1'b1 && cycles < max) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pc = '0; inv = 1'b0;
        step();
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", hit); end
        model_clear();
        ack_log.delete();
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_cold_miss();
        int cyc;
        logic [1023:0] exp_line;
        pc = 32'h0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL cold_pre_hit got=%b exp=0", hit); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL cold_fill_start req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
        wait_hit(200, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL cold_latency got=%0d exp=33", cyc); end
        checks++; if (ack_log.size() != 32) begin errors++; $display("FAIL cold_ack_count got=%0d exp=32", ack_log.size()); end
        for (int k = 0; k < 32 && k < ack_log.size(); k++) begin
            checks++; if (ack_log[k] !== 32'(4 * k)) begin errors++; $display("FAIL cold_addr_seq k=%0d got=%h exp=%h", k, ack_log[k], 32'(4 * k)); end
        end
        checks++; if (line[1023:992] !== 32'hA000_0000) begin errors++; $display("FAIL cold_first_word got=%h exp=a0000000", line[1023:992]); end
        checks++; if (line[31:0] !== 32'hA000_001F) begin errors++; $display("FAIL cold_last_word got=%h exp=a000001f", line[31:0]); end
        exp_line = line_of(32'h0);
        checks++; if (line !== exp_line) begin errors++; $display("FAIL cold_line w=%0d got=%h exp=%h", first_diff(line, exp_line), line[1023-32*first_diff(line, exp_line) -: 32], exp_line[1023-32*first_diff(line, exp_line) -: 32]); end
        model_fill(32'h0);
        $display("txn cold fill base=00000000 cycles=%0d", cyc);
    endtask

    task automatic test_hit_conflict();
        int cyc;
        logic [1023:0] exp_line;
        pc = 32'd128;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conf_128_miss got=%b exp=0", hit); end
        ack_log.delete();
        step();
        checks++; if (mem_addr !== 32'd128) begin errors++; $display("FAIL conf_128_start got=%h exp=00000080", mem_addr); end
        wait_hit(200, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL conf_128_latency got=%0d exp=33", cyc); end
        checks++; if (ack_log.size() != 32 || ack_log[0] !== 32'd128 || ack_log[ack_log.size()-1] !== 32'd252) begin errors++; $display("FAIL conf_128_range n=%0d exp n=32 128..252", ack_log.size()); end
        model_fill(32'd128);
        pc = 32'h0;
        #1;
        checks++; if (hit !== model_hit(32'h0)) begin errors++; $display("FAIL conf_hit0 got=%b exp=%b", hit, model_hit(32'h0)); end
        exp_line = line_of(32'h0);
        checks++; if (line !== exp_line) begin errors++; $display("FAIL conf_out0 w=%0d", first_diff(line, exp_line)); end
        pc = 32'd1024;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conf_1024_miss got=%b exp=0", hit); end
        ack_log.delete();
        step();
        wait_hit(200, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL conf_1024_latency got=%0d exp=33", cyc); end
        exp_line = line_of(32'd1024);
        checks++; if (line !== exp_line) begin errors++; $display("FAIL conf_out1024 w=%0d", first_diff(line, exp_line)); end
        model_fill(32'd1024);
        pc = 32'h0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL conf_0_evicted got=%b exp=0", hit); end
        pc = 32'd1024;
        $display("txn conflict fills 128 and 1024 done");
    endtask

    task automatic test_mid_fill_change();
        int cyc;
        int guard;
        logic [1023:0] exp_line;
        ack_log.delete();
        pc = 32'h0;
        step();
        guard = 0;
        while (ack_log.size() < 11 && guard < 200) begin step(); guard++; end
        pc = 32'd256;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL mid_hit_during_fill got=%b exp=0", hit); end
        guard = 0;
        while (mem_req === 1'b1 && guard < 200) begin step(); guard++; end
        checks++; if (ack_log.size() != 32 || ack_log[10] !== 32'd40 || ack_log[ack_log.size()-1] !== 32'd124) begin errors++; $display("FAIL mid_latched_base n=%0d exp n=32 0..124", ack_log.size()); end
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mid_idle_after_write got=%b exp=0", mem_req); end
        model_fill(32'h0);
        ack_log.delete();
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd256) begin errors++; $display("FAIL mid_next_fill req=%b addr=%h exp req=1 addr=00000100", mem_req, mem_addr); end
        wait_hit(200, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL mid_256_latency got=%0d exp=33", cyc); end
        model_fill(32'd256);
        pc = 32'h0;
        #1;
        exp_line = line_of(32'h0);
        checks++; if (hit !== model_hit(32'h0)) begin errors++; $display("FAIL mid_line0_valid got=%b exp=1", hit); end
        checks++; if (line !== exp_line) begin errors++; $display("FAIL mid_line0_data w=%0d", first_diff(line, exp_line)); end
        $display("txn mid-fill address change done");
    endtask

    task automatic test_wait_states();
        int cyc;
        logic [1023:0] exp_line;
        wait_cycles = 3;
        stable_viol = 0;
        pc = 32'd384;
        ack_log.delete();
        step();
        wait_hit(1000, cyc);
        checks++; if (cyc != 129) begin errors++; $display("FAIL wait_latency got=%0d exp=129", cyc); end
        checks++; if (stable_viol != 0) begin errors++; $display("FAIL wait_addr_stable got=%0d violations exp=0", stable_viol); end
        checks++; if (ack_log.size() != 32) begin errors++; $display("FAIL wait_ack_count got=%0d exp=32", ack_log.size()); end
        exp_line = line_of(32'd384);
        checks++; if (line !== exp_line) begin errors++; $display("FAIL wait_line w=%0d", first_diff(line, exp_line)); end
        model_fill(32'd384);
        wait_cycles = 0;
        $display("txn wait-state fill base=00000180 cycles=%0d", cyc);
    endtask

    task automatic test_invalidate();
        int cyc;
        int guard;
        logic [31:0] probe[4] = '{32'h0, 32'd128, 32'd256, 32'd384};
        ack_log.delete();
        pc = 32'd512;
        step();
        guard = 0;
        while (ack_log.size() < 6 && guard < 200) begin step(); guard++; end
        inv = 1'b1;
        step();
        model_clear();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL inv_fill_abort got=%b exp=0", mem_req); end
        for (int i = 0; i < 4; i++) begin
            pc = probe[i];
            step();
            checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_probe addr=%h got=%b exp=0", probe[i], hit); end
        end
        inv = 1'b0;
        pc = 32'd512;
        ack_log.delete();
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd512) begin errors++; $display("FAIL inv_refill_word0 req=%b addr=%h exp req=1 addr=00000200", mem_req, mem_addr); end
        wait_hit(200, cyc);
        checks++; if (cyc != 33 || ack_log.size() != 32) begin errors++; $display("FAIL inv_refill cycles=%0d acks=%0d exp 33/32", cyc, ack_log.size()); end
        model_fill(32'd512);
        pc = 32'd640;
        step();
        guard = 0;
        while (mem_req === 1'b1 && guard < 200) begin step(); guard++; end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_write_cycle_hit got=%b exp=0", hit); end
        inv = 1'b1;
        step();
        model_clear();
        checks++; if (mem_req !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL inv_on_write req=%b hit=%b exp 0/0", mem_req, hit); end
        pc = 32'd512;
        step();
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL inv_cleared_512 got=%b exp=0", hit); end
        inv = 1'b0;
        pc = 32'd640;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd640) begin errors++; $display("FAIL inv_write_refill req=%b addr=%h exp req=1 addr=00000280", mem_req, mem_addr); end
        wait_hit(200, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL inv_write_refill_latency got=%0d exp=33", cyc); end
        model_fill(32'd640);
        $display("txn invalidate scenarios done");
    endtask

    task automatic test_random();
        int cyc;
        int w;
        logic [31:0] addr;
        logic [31:0] base;
        logic [1023:0] exp_line;
        bit exp_hit;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                inv = 1'b1;
                step();
                inv = 1'b0;
                model_clear();
            end
            case ($urandom_range(0, 2))
                0: addr = 32'h0;
                1: addr = 32'h400;
                default: addr = 32'hFFFF_FC00;
            endcase
            addr = addr | (32'($urandom_range(0, 7)) << 7) | 32'($urandom_range(0, 127));
            base = addr & ~32'h7F;
            pc = addr;
            #1;
            exp_hit = model_hit(addr);
            checks++; if (hit !== exp_hit) begin errors++; $display("FAIL rnd_hit addr=%h got=%b exp=%b", addr, hit, exp_hit); end
            if (!exp_hit) begin
                w = $urandom_range(0, 3);
                wait_cycles = w;
                stable_viol = 0;
                ack_log.delete();
                step();
                checks++; if (mem_addr !== base) begin errors++; $display("FAIL rnd_fill_start addr=%h got=%h exp=%h", addr, mem_addr, base); end
                wait_hit(1000, cyc);
                checks++; if (cyc != 32 * (w + 1) + 1) begin errors++; $display("FAIL rnd_latency addr=%h wait=%0d got=%0d exp=%0d", addr, w, cyc, 32 * (w + 1) + 1); end
                checks++; if (stable_viol != 0) begin errors++; $display("FAIL rnd_addr_stable got=%0d exp=0", stable_viol); end
                model_fill(base);
            end
            exp_line = line_of(base);
            checks++; if (line !== exp_line) begin errors++; $display("FAIL rnd_line addr=%h w=%0d", addr, first_diff(line, exp_line)); end
            $display("txn rnd n=%0d addr=%h hit_expected=%0d", n, addr, exp_hit);
        end
        wait_cycles = 0;
    endtask

    task automatic test_async_reset();
        int cyc;
        int guard;
        logic [1023:0] exp_line;
        inv = 1'b1;
        step();
        inv = 1'b0;
        model_clear();
        pc = 32'h0;
        ack_log.delete();
        step();
        guard = 0;
        while (ack_log.size() < 21 && guard < 200) begin step(); guard++; end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL arst_req_drop got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0 || hit !== 1'b0) begin errors++; $display("FAIL arst_outputs addr=%h hit=%b exp 0/0", mem_addr, hit); end
        model_clear();
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL arst_post_miss got=%b exp=0", hit); end
        ack_log.delete();
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL arst_refill req=%b addr=%h exp req=1 addr=0", mem_req, mem_addr); end
        wait_hit(200, cyc);
        checks++; if (cyc != 33) begin errors++; $display("FAIL arst_refill_latency got=%0d exp=33", cyc); end
        exp_line = line_of(32'h0);
        checks++; if (line !== exp_line) begin errors++; $display("FAIL arst_line w=%0d", first_diff(line, exp_line)); end
        model_fill(32'h0);
        $display("txn async reset mid-fill done");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_conflict();
        test_mid_fill_change();
        test_wait_states();
        test_invalidate();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_line_cache.md
# inst_line_cache

Direct-mapped instruction line cache that answers the fetch stage's `in`/`out`/`hit` lookup. The fetch stage drives a line-aligned byte PC and consumes a 1024-bit line, taking the first word from bits [1023:992] and walking downward. On a miss, the block runs a word-serial refill from instruction memory over a req/ack handshake and then raises `hit` for the requested line. It sits between the fetch stage and instruction memory.

## Interface
- `WORD_SIZE`, 32, instruction word width in bits.
- `LINE_WORDS`, 32, words per line. The line is 1024 bits, which is 128 bytes.
- `NUM_LINES`, 8, number of direct-mapped lines. Must be a power of two.
- `ADDR_WIDTH`, 32, byte address width.

- `clk`  in  1  Single clock. All state updates on the posedge.
- `rst`  in  1  Asynchronous, active-high reset.
- `in`  in  ADDR_WIDTH  Fetch PC, in bytes. Bits [6:0] are ignored.
- `out`  out  WORD_SIZE*LINE_WORDS  Line data for the index selected by `in`.
- `hit`  out  1  `out` holds valid data for `in`.
- `inv`  in  1  Invalidate all lines.
- `mem_req`  out  1  Word read request to instruction memory.
- `mem_addr`  out  ADDR_WIDTH  Byte address of the requested word. Always word-aligned.
- `mem_ack`  in  1  Memory returns a word this cycle.
- `mem_rdata`  in  WORD_SIZE  Word returned with `mem_ack`.

## Operation
- **Address split.**
  - offset = `in`[6:0], ignored.
  - index = `in`[6+log2(NUM_LINES):7].
  - tag = remaining upper bits.
- **Storage.** Per line: a valid bit, a tag, and 1024 bits of data.
- **Lookup (combinational).**
  - `out` = data[index].
  - `hit` = valid[index] && tag match && !(state==WRITE && fill index==index).
- **State machine.** States are IDLE, FILL and WRITE.
- **IDLE.**
  - Stay in IDLE while there is a hit, or while `inv`=1.
  - On a miss with `inv`=0:
    - latch base = {`in`[ADDR_WIDTH-1:7], 7'b0};
    - set word counter k=0;
    - go to FILL.
- **FILL.**
  - `mem_req`=1 and `mem_addr`=base+4k.
  - On `mem_ack`: write `mem_rdata` into fill buffer bits [1023-32k : 992-32k], then increment k.
  - `mem_addr` advances in the cycle after each ack.
  - The ack for k=31 goes to WRITE.
- **WRITE (one cycle).**
  - `mem_req`=0.
  - Copy the fill buffer into data[fill index], set the tag, set the valid bit.
  - Return to IDLE.
- **`in` changes during FILL.** The fill completes for the latched base. The new address is evaluated in IDLE afterwards.
- **`inv`.**
  - Clears all valid bits at the next posedge.
  - Aborts FILL or WRITE to IDLE; the partial or complete line is not validated.
  - `inv` wins over a simultaneous WRITE.
- **Bus protocol.**
  - One outstanding request at a time.
  - `mem_addr` is stable while `mem_req`=1 and no ack has arrived.
  - `mem_ack` while `mem_req`=0 is ignored.

## Timing
- **Reset values.**
  - Outputs: `mem_req`=0, `mem_addr`=0, `hit`=0.
  - Internal: all valid bits 0, state IDLE, k=0.
  - `out` is don't-care, but never X-propagating into `hit`.
- **Reset mid-fill.** `mem_req` drops immediately (asynchronous). No line is validated.
- **Hit latency.** Zero cycles: `hit` and `out` follow `in` combinationally.
- **Miss latency.**
  - FILL is entered at the posedge after the miss is seen.
  - With `mem_ack` returned in the first cycle of each request, `hit` rises 33 cycles after FILL entry: 32 FILL cycles plus 1 WRITE cycle.
  - Each memory wait cycle adds one cycle.
- **Address wrap.** base+4k wraps modulo 2^ADDR_WIDTH.

## Test plan
- **Cold miss.**
  - Stimulus: reset, then `in`=0. Memory returns word k = 32'hA000_0000+k with zero wait.
  - Required: `mem_addr` sequence 0,4,…,124. `hit`=1 after 33 cycles. `out`[1023:992]=A000_0000 and `out`[31:0]=A000_001F.
- **Hit and conflict.**
  - Stimulus: after the cold fill, set `in`=128, then `in`=1024.
  - Required: `in`=128 gives `hit`=0 and a fill of 128..252. `in`=1024 (same index 0 as address 0) misses and refills, after which `in`=0 misses.
- **Wait states.**
  - Stimulus: `mem_ack` delayed 3 cycles per word.
  - Required: `mem_addr` holds steady while unacked. `hit` after 32*4+1=129 cycles.
- **Address change mid-fill.**
  - Stimulus: `in` moves from 0 to 256 at k=10.
  - Required: line 0 completes and is validated. The fill for 256 starts the cycle after WRITE.
- **Invalidate.**
  - Stimulus: `inv` pulse during FILL at k=5, and `inv` on the WRITE cycle.
  - Required: `mem_req`=0 the next cycle. `hit`=0 for every address. The next lookup refills from word 0.
- **Async reset mid-fill.**
  - Stimulus: assert `rst` asynchronously at k=20.
  - Required: `mem_req`=0 immediately. After release, `in`=0 misses.
